bpsk_tx_scheduler: RTL and testbench
====================================

# bpsk_tx_scheduler

Transmit-side controller for the BPSK chain. It accepts payload bytes from an upstream source through a valid/ready handshake and frames them with a fixed preamble. It serialises the frame MSB-first into the single-bit `data_in` of the bipolar converter, holding each bit for a programmable number of clocks. It also emits symbol and frame strobes that the Costas loop and demodulator bench logic use for alignment and gating.

## Interface
Parameters:
- `SYM_CYCLES`, 1000: clocks per symbol (bit). Legal range 2..65535.
- `PRE_PATTERN`, 8'b0101_0101: preamble, sent MSB first.
- `MAX_BYTES`, 16: maximum payload bytes per frame. Legal range 1..255.
- `GAP_SYMS`, 4: idle symbols forced after each frame. Legal range 1..255.

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `byte_in`, in, 8: payload byte.
- `byte_valid`, in, 1: `byte_in` is valid.
- `byte_ready`, out, 1: the block accepts `byte_in` this cycle. Combinational from state and counters.
- `tx_bit`, out, 1: serial bit to the bipolar converter. Registered.
- `sym_start`, out, 1: one-cycle pulse coincident with the first cycle of every preamble and payload symbol.
- `tx_active`, out, 1: high from the first preamble cycle through the last gap cycle.
- `frame_start`, out, 1: one-cycle pulse on the first preamble cycle.
- `frame_done`, out, 1: one-cycle pulse on the first IDLE cycle after a gap.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, GAP.
- Counters:
  - `sym_cnt` counts 0..SYM_CYCLES-1 and wraps to 0.
  - `bit_cnt` counts 0..7.
  - `byte_cnt` counts 0..MAX_BYTES.
  - `gap_cnt` counts 0..GAP_SYMS-1.
  - A symbol ends on a cycle with `sym_cnt`==SYM_CYCLES-1.
- Storage:
  - 8-bit holding register `hold`.
  - 8-bit shift register `sh`; `tx_bit`=`sh[7]` while in PREAMBLE or PAYLOAD, otherwise 0.
- IDLE:
  - `byte_ready`=1.
  - On `byte_valid`: `hold`←`byte_in`, `sh`←PRE_PATTERN, counters←0, `byte_cnt`←1, next state PREAMBLE.
- PREAMBLE:
  - `byte_ready`=0.
  - At each symbol end, shift `sh` left and increment `bit_cnt`.
  - At the end of symbol 7: `sh`←`hold`, `bit_cnt`←0, next state PAYLOAD.
- PAYLOAD:
  - At each symbol end except the last bit, shift `sh` left.
  - `byte_ready`=1 only on the final cycle of bit 7 and only if `byte_cnt`<MAX_BYTES.
  - On that cycle, if `byte_valid`: `sh`←`byte_in`, `byte_cnt`++, stay in PAYLOAD, with no idle symbol between bytes.
  - Otherwise next state GAP, `gap_cnt`←0.
- GAP:
  - `byte_ready`=0 and `tx_bit`=0; `byte_valid` is ignored.
  - After GAP_SYMS symbols, next state IDLE with `frame_done`=1 on the first IDLE cycle.
- `sym_cnt` free-runs in PREAMBLE, PAYLOAD and GAP, and is held at 0 in IDLE.
- A byte is transferred only on a cycle with `byte_valid`&&`byte_ready`. `byte_in` is not sampled at any other time.

## Timing
- Reset state: IDLE, all counters 0, `tx_bit`=0, `sym_start`=0, `tx_active`=0, `frame_start`=0, `frame_done`=0, `byte_ready`=1 from the cycle after the reset edge.
- Reset mid-operation: on the next edge, return to the reset state. Any held or partially shifted byte is discarded, and `frame_done` is not pulsed.
- Acceptance in IDLE at edge T:
  - PREAMBLE begins at T+1 with `tx_active`=1, `frame_start`=1, `sym_start`=1, `tx_bit`=PRE_PATTERN[7].
  - The first payload bit appears at T+1+8·SYM_CYCLES.
- A frame of N bytes keeps `tx_active` high for (8+8N+GAP_SYMS)·SYM_CYCLES cycles exactly.
- Byte boundaries and limits:
  - A byte accepted on the final cycle of bit 7 drives its MSB on the very next cycle.
  - When `byte_cnt`==MAX_BYTES, `byte_ready` stays 0 at the byte boundary and the frame closes.
- Simultaneous events:
  - If `rst` and `byte_valid` are both high, reset wins and nothing is accepted.
  - `frame_done` and a new acceptance may occur on the same IDLE cycle. The new frame's `frame_start` then follows one cycle later.

## Test plan
- SYM_CYCLES=4, one byte 0xA5 then `byte_valid`=0 → `tx_bit` is 0,1,0,1,0,1,0,1 then 1,0,1,0,0,1,0,1, each held 4 cycles, then 0 for 16 gap cycles. `tx_active` is high for 80 cycles, with `frame_start` and `frame_done` pulsed once each.
- Back-to-back 0xFF, 0x00 with `byte_valid` held high → `byte_ready` pulses for exactly one cycle, at cycle 63 after start. The 0xFF bits are followed by the 0x00 bits with no gap, and `sym_start` pulses 24 times.
- MAX_BYTES=2 with `byte_valid` held high for 5 bytes → exactly 2 payload bytes are sent, then the gap. A new frame starts with byte 3 on the first IDLE cycle after `frame_done`.
- `rst` asserted during payload bit 3 → the next cycle shows the reset values on all outputs and `byte_ready`=1. A following byte 0x3C produces a clean full frame.
- `byte_valid` toggled high during PREAMBLE and GAP → no acceptance occurs and the transmitted sequence is unchanged.
- SYM_CYCLES=2 with random byte streams and random `byte_valid` gaps → a scoreboard reconstructs the bytes from `tx_bit` sampled at `sym_start` and matches the accepted byte sequence.

Source files
------------

// File: rtl/bpsk_tx_scheduler.sv
// BPSK transmit scheduler: frames payload bytes behind a fixed preamble and
// serialises them MSB-first, one bit per SYM_CYCLES clocks, followed by a
// forced idle gap. Emits symbol/frame strobes for downstream alignment.
module bpsk_tx_scheduler #(
  parameter int unsigned SYM_CYCLES  = 1000,
  parameter logic [7:0]  PRE_PATTERN = 8'b0101_0101,
  parameter int unsigned MAX_BYTES   = 16,
  parameter int unsigned GAP_SYMS    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx_bit,
  output logic       sym_start,
  output logic       tx_active,
  output logic       frame_start,
  output logic       frame_done
);

  localparam int unsigned SYM_W  = 16;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned GAP_W  = 8;

  localparam logic [SYM_W-1:0]  SYM_LAST = SYM_W'(SYM_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(7);
  localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(MAX_BYTES);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_SYMS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_PAYLOAD,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [SYM_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [7:0]          hold_q, hold_d;
  logic [7:0]          sh_q, sh_d;

  logic                tx_bit_d;
  logic                sym_start_d;
  logic                tx_active_d;
  logic                frame_start_d;
  logic                frame_done_d;

  logic                sym_end;
  logic                last_bit;
  logic                room_left;
  logic                sending_d;

  assign sym_end   = (sym_cnt_q == SYM_LAST);
  assign last_bit  = (bit_cnt_q == BIT_LAST);
  assign room_left = (byte_cnt_q < BYTE_MAX);

  // State register, counters, data path and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sym_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      hold_q      <= '0;
      sh_q        <= '0;
      tx_bit      <= 1'b0;
      sym_start   <= 1'b0;
      tx_active   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_q      <= hold_d;
      sh_q        <= sh_d;
      tx_bit      <= tx_bit_d;
      sym_start   <= sym_start_d;
      tx_active   <= tx_active_d;
      frame_start <= frame_start_d;
      frame_done  <= frame_done_d;
    end
  end

  // Next-state, counter/shift-register updates and handshake decode
  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_end ? '0 : sym_cnt_q + SYM_W'(1);
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    hold_d     = hold_q;
    sh_d       = sh_q;
    byte_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        sym_cnt_d  = '0;
        byte_ready = 1'b1;
        if (byte_valid) begin
          hold_d     = byte_in;
          sh_d       = PRE_PATTERN;
          bit_cnt_d  = '0;
          gap_cnt_d  = '0;
          byte_cnt_d = BYTE_W'(1);
          state_d    = S_PREAMBLE;
        end
      end

      S_PREAMBLE: begin
        if (sym_end) begin
          if (last_bit) begin
            sh_d      = hold_q;
            bit_cnt_d = '0;
            state_d   = S_PAYLOAD;
          end else begin
            sh_d      = {sh_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      S_PAYLOAD: begin
        if (sym_end) begin
          if (last_bit) begin
            // Byte boundary: chain the next byte with no idle symbol, or close
            byte_ready = room_left;
            bit_cnt_d  = '0;
            if (byte_valid && room_left) begin
              sh_d       = byte_in;
              byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            end else begin
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end
          end else begin
            sh_d      = {sh_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      S_GAP: begin
        if (sym_end) begin
          if (gap_cnt_q == GAP_LAST) begin
            sym_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    sending_d     = (state_d == S_PREAMBLE) || (state_d == S_PAYLOAD);
    tx_bit_d      = sending_d & sh_d[7];
    sym_start_d   = sending_d && (sym_cnt_d == '0);
    tx_active_d   = (state_d != S_IDLE);
    frame_start_d = (state_q == S_IDLE) && (state_d == S_PREAMBLE);
    frame_done_d  = (state_q == S_GAP) && (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Bench for bpsk_tx_scheduler: two instances (slow/short-frame and fast/long
// frame) checked every cycle against a frame-time reference model, plus a
// vector table and directed sequences for the multi-cycle corner cases.
module tb_bpsk_tx_scheduler;

  localparam int          SA = 4;
  localparam int          MA = 2;
  localparam int          GA = 4;
  localparam logic [7:0]  PA = 8'h55;
  localparam int          SB = 2;
  localparam int          MB = 5;
  localparam int          GB = 3;
  localparam logic [7:0]  PB = 8'hB4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, valid_a = 1'b0;
  logic [7:0] din_a = 8'h00;
  logic       byte_ready_a, tx_bit_a, sym_start_a, tx_active_a, frame_start_a, frame_done_a;
  logic       rst_b = 1'b1, valid_b = 1'b0;
  logic [7:0] din_b = 8'h00;
  logic       byte_ready_b, tx_bit_b, sym_start_b, tx_active_b, frame_start_b, frame_done_b;

  bpsk_tx_scheduler #(.SYM_CYCLES(SA), .PRE_PATTERN(PA), .MAX_BYTES(MA), .GAP_SYMS(GA)) u_dut_a (
    .clk(clk), .rst(rst_a), .byte_in(din_a), .byte_valid(valid_a), .byte_ready(byte_ready_a),
    .tx_bit(tx_bit_a), .sym_start(sym_start_a), .tx_active(tx_active_a),
    .frame_start(frame_start_a), .frame_done(frame_done_a));

  bpsk_tx_scheduler #(.SYM_CYCLES(SB), .PRE_PATTERN(PB), .MAX_BYTES(MB), .GAP_SYMS(GB)) u_dut_b (
    .clk(clk), .rst(rst_b), .byte_in(din_b), .byte_valid(valid_b), .byte_ready(byte_ready_b),
    .tx_bit(tx_bit_b), .sym_start(sym_start_b), .tx_active(tx_active_b),
    .frame_start(frame_start_b), .frame_done(frame_done_b));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame time based) ----------------
  typedef struct packed {
    logic tx_bit;
    logic sym_start;
    logic tx_active;
    logic frame_start;
    logic frame_done;
    logic byte_ready;
  } obs_t;

  typedef struct packed {
    logic             in_frame;
    logic             closed;
    logic             done;
    int               t;
    int               pay_end;
    int               nb;
    logic [15:0][7:0] q;
  } model_t;

  function automatic obs_t model_out(input model_t m, input int s, input int mx, input logic [7:0] pre);
    obs_t e;
    int p, k, b;
    e = '0;
    if (!m.in_frame) begin
      e.byte_ready = 1'b1;
      e.frame_done = m.done;
    end else begin
      e.tx_active   = 1'b1;
      e.frame_start = (m.t == 0);
      if (m.t < 8 * s) begin
        e.tx_bit    = pre[3'(7 - m.t / s)];
        e.sym_start = (m.t % s == 0);
      end else if (!m.closed || m.t < m.pay_end) begin
        p = m.t - 8 * s;
        k = p / (8 * s);
        b = (p / s) % 8;
        e.tx_bit     = m.q[4'(k)][3'(7 - b)];
        e.sym_start  = (p % s == 0);
        e.byte_ready = (p % (8 * s) == 8 * s - 1) && (k + 1 < mx);
      end
    end
    return e;
  endfunction

  function automatic model_t model_step(input model_t m, input int s, input int mx, input int gp,
                                        input logic rst, input logic valid, input logic [7:0] din);
    model_t r;
    int p;
    r = m;
    if (rst) begin
      r = '0;
    end else if (!m.in_frame) begin
      r.done = 1'b0;
      if (valid) begin
        r.in_frame = 1'b1;
        r.closed   = 1'b0;
        r.t        = 0;
        r.nb       = 1;
        r.q        = '0;
        r.q[0]     = din;
      end
    end else begin
      if (!m.closed && m.t >= 8 * s) begin
        p = m.t - 8 * s;
        if (p % (8 * s) == 8 * s - 1) begin
          if (valid && m.nb < mx) begin
            r.q[4'(m.nb)] = din;
            r.nb          = m.nb + 1;
          end else begin
            r.closed  = 1'b1;
            r.pay_end = m.t + 1;
          end
        end
      end
      r.t = m.t + 1;
      if (r.closed && r.t == r.pay_end + gp * s) begin
        r.in_frame = 1'b0;
        r.done     = 1'b1;
      end
    end
    return r;
  endfunction

  model_t ma = '0, mb = '0;
  logic   on_a = 1'b0, on_b = 1'b0;
  obs_t   obs_a, obs_b;
  assign obs_a = {tx_bit_a, sym_start_a, tx_active_a, frame_start_a, frame_done_a, byte_ready_a};
  assign obs_b = {tx_bit_b, sym_start_b, tx_active_b, frame_start_b, frame_done_b, byte_ready_b};

  // Advance both models on the active edge with the inputs presented that cycle
  always @(posedge clk) begin
    if (rst_a) on_a <= 1'b1;
    if (rst_b) on_b <= 1'b1;
    ma <= model_step(ma, SA, MA, GA, rst_a, valid_a, din_a);
    mb <= model_step(mb, SB, MB, GB, rst_b, valid_b, din_b);
  end

  // Compare every output of both instances against the model each cycle
  always @(negedge clk) begin
    if (on_a) check("model_a outputs", 32'(obs_a), 32'(model_out(ma, SA, MA, PA)));
    if (on_b) check("model_b outputs", 32'(obs_b), 32'(model_out(mb, SB, MB, PB)));
  end

  // ---------------- monitors / scoreboards ----------------
  int          act_a = 0, fs_a = 0, fd_a = 0, ss_a = 0, rdyact_a = 0, b2b_a = 0;
  int          cyc_a = 0, fs_cyc_a = 0, rdy_rel_a = -1, sidx_a = 0;
  logic        prev_fd_a = 1'b0;
  logic [31:0] bits_a = '0;
  logic [7:0]  sr_a = '0;
  logic [7:0]  rx_a[$], acc_a[$];
  int          sidx_b = 0;
  logic [7:0]  sr_b = '0;
  logic [7:0]  rx_b[$], acc_b[$];

  // Count strobes and rebuild payload bytes from tx_bit at each sym_start
  always @(negedge clk) begin
    cyc_a++;
    if (tx_active_a === 1'b1) act_a++;
    if (frame_start_a === 1'b1) begin
      fs_a++;
      fs_cyc_a = cyc_a;
      if (prev_fd_a) b2b_a++;
    end
    if (frame_done_a === 1'b1) fd_a++;
    prev_fd_a = (frame_done_a === 1'b1);
    if (tx_active_a === 1'b1 && byte_ready_a === 1'b1) begin
      rdyact_a++;
      rdy_rel_a = cyc_a - fs_cyc_a;
    end
    if (!rst_a && valid_a && byte_ready_a === 1'b1) acc_a.push_back(din_a);
    if (sym_start_a === 1'b1) begin
      ss_a++;
      bits_a = {bits_a[30:0], tx_bit_a};
      if (frame_start_a) sidx_a = 0;
      if (sidx_a >= 8) begin
        sr_a = {sr_a[6:0], tx_bit_a};
        if (sidx_a % 8 == 7) rx_a.push_back(sr_a);
      end
      sidx_a++;
    end

    if (!rst_b && valid_b && byte_ready_b === 1'b1) acc_b.push_back(din_b);
    if (sym_start_b === 1'b1) begin
      if (frame_start_b) sidx_b = 0;
      if (sidx_b >= 8) begin
        sr_b = {sr_b[6:0], tx_bit_b};
        if (sidx_b % 8 == 7) rx_b.push_back(sr_b);
      end
      sidx_b++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] din;
    int         reps;
    logic       chk;
    logic       e_bit;
    logic       e_act;
    logic       e_rdy;
    logic       e_ss0;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic v, input logic [7:0] d, input int n,
                               input logic c, input logic eb, input logic ea, input logic er,
                               input logic es);
    vec_t x;
    x.rst = r; x.valid = v; x.din = d; x.reps = n; x.chk = c;
    x.e_bit = eb; x.e_act = ea; x.e_rdy = er; x.e_ss0 = es;
    return x;
  endfunction

  task automatic run_a();
    vec_t       tbl[$];
    logic [7:0] pre, pay;
    logic [7:0] t3b[5];
    int         a0, f0, d0, s0, y0, r0, c0, b0, sent;
    pre = PA;
    pay = 8'hA5;

    // Reset (with a simultaneous valid), reset state, then one-byte frame 0xA5
    tbl.push_back(mkv(1'b1, 1'b1, 8'h77, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 8'h00, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b1, pay,   1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mkv(1'b0, 1'b0, 8'h00, 4, 1'b1, pre[3'(7 - i)], 1'b1, 1'b0, 1'b1));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mkv(1'b0, 1'b0, 8'h00, 4, 1'b1, pay[3'(7 - i)], 1'b1, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b0, 1'b0, 8'h00, 3,  1'b1, pay[0], 1'b1, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b0, 1'b0, 8'h00, 1,  1'b1, pay[0], 1'b1, 1'b1, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 8'h00, 16, 1'b1, 1'b0,   1'b1, 1'b0, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 8'h00, 2,  1'b1, 1'b0,   1'b0, 1'b1, 1'b0));

    a0 = act_a; f0 = fs_a; d0 = fd_a;
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        rst_a = tbl[i].rst; valid_a = tbl[i].valid; din_a = tbl[i].din;
        @(negedge clk);
        if (tbl[i].chk)
          check($sformatf("vec%0d.%0d {tx_bit,tx_active,byte_ready,sym_start}", i, r),
                32'({tx_bit_a, tx_active_a, byte_ready_a, sym_start_a}),
                32'({tbl[i].e_bit, tbl[i].e_act, tbl[i].e_rdy, (r == 0) ? tbl[i].e_ss0 : 1'b0}));
        @(posedge clk);
        #1;
      end
    end
    valid_a = 1'b0;
    check("t1 tx_active cycles", 32'(act_a - a0), 32'd80);
    check("t1 frame_start count", 32'(fs_a - f0), 32'd1);
    check("t1 frame_done count", 32'(fd_a - d0), 32'd1);

    // Back-to-back 0xFF, 0x00 with valid held high
    a0 = act_a; s0 = ss_a; y0 = rdyact_a; r0 = rx_a.size();
    valid_a = 1'b1; din_a = 8'hFF; tick();
    din_a = 8'h00;
    repeat (64) tick();
    valid_a = 1'b0;
    repeat (52) tick();
    check("t2 byte_ready pulses in frame", 32'(rdyact_a - y0), 32'd1);
    check("t2 byte_ready cycle after start", 32'(rdy_rel_a), 32'd63);
    check("t2 sym_start count", 32'(ss_a - s0), 32'd24);
    check("t2 symbol stream", bits_a & 32'h00FF_FFFF, 32'h0055_FF00);
    check("t2 tx_active cycles", 32'(act_a - a0), 32'd112);
    check("t2 rx byte count", 32'(rx_a.size() - r0), 32'd2);
    if (rx_a.size() >= r0 + 2) begin
      check("t2 rx byte0", 32'(rx_a[r0]), 32'hFF);
      check("t2 rx byte1", 32'(rx_a[r0 + 1]), 32'h00);
    end

    // MAX_BYTES limit with a 5-byte stream and valid held high
    t3b = '{8'hC3, 8'h5A, 8'h0F, 8'hE7, 8'h99};
    f0 = fs_a; d0 = fd_a; b0 = b2b_a; r0 = rx_a.size(); sent = 0;
    for (int c = 0; c < 400; c++) begin
      valid_a = (sent < 5);
      din_a   = (sent < 5) ? t3b[sent] : 8'h00;
      @(negedge clk);
      if (valid_a && byte_ready_a === 1'b1) sent++;
      @(posedge clk);
      #1;
    end
    valid_a = 1'b0;
    check("t3 bytes accepted", 32'(sent), 32'd5);
    check("t3 frame_start count", 32'(fs_a - f0), 32'd3);
    check("t3 frame_done count", 32'(fd_a - d0), 32'd3);
    check("t3 start right after done", 32'(b2b_a - b0), 32'd2);
    check("t3 rx byte count", 32'(rx_a.size() - r0), 32'd5);
    for (int j = 0; j < 5; j++)
      if (rx_a.size() > r0 + j) check($sformatf("t3 rx byte%0d", j), 32'(rx_a[r0 + j]), 32'(t3b[j]));

    // Reset during payload bit 3, then a clean frame
    valid_a = 1'b1; din_a = 8'h96; tick();
    valid_a = 1'b0;
    repeat (45) tick();
    d0 = fd_a;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    @(negedge clk);
    check("t4 outputs after reset", 32'(obs_a), 32'b000001);
    a0 = act_a; r0 = rx_a.size();
    tick();
    valid_a = 1'b1; din_a = 8'h3C; tick();
    valid_a = 1'b0;
    repeat (84) tick();
    check("t4 frame_done count", 32'(fd_a - d0), 32'd1);
    check("t4 tx_active cycles", 32'(act_a - a0), 32'd80);
    check("t4 rx byte count", 32'(rx_a.size() - r0), 32'd1);
    if (rx_a.size() > r0) check("t4 rx byte", 32'(rx_a[r0]), 32'h3C);

    // valid toggled during PREAMBLE and GAP must not be accepted
    a0 = act_a; r0 = rx_a.size(); c0 = acc_a.size();
    valid_a = 1'b1; din_a = 8'h81; tick();
    for (int c = 0; c < 80; c++) begin
      valid_a = (c < 32 || (c >= 64 && c < 76)) ? 1'($urandom_range(0, 1)) : 1'b0;
      din_a   = 8'($urandom);
      tick();
    end
    valid_a = 1'b0;
    repeat (3) tick();
    check("t5 accepted count", 32'(acc_a.size() - c0), 32'd1);
    check("t5 tx_active cycles", 32'(act_a - a0), 32'd80);
    check("t5 rx byte count", 32'(rx_a.size() - r0), 32'd1);
    if (rx_a.size() > r0) check("t5 rx byte", 32'(rx_a[r0]), 32'h81);
  endtask

  // Random byte stream with random valid gaps on the fast instance
  task automatic run_b();
    rst_b = 1'b1;
    repeat (2) tick();
    rst_b = 1'b0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      valid_b = ($urandom_range(0, 2) == 0);
      din_b   = 8'($urandom);
      tick();
    end
    valid_b = 1'b0;
    repeat (120) tick();
    check("t6 rx vs accepted count", 32'(rx_b.size()), 32'(acc_b.size()));
    for (int j = 0; j < acc_b.size(); j++)
      if (j < rx_b.size()) check($sformatf("t6 byte%0d", j), 32'(rx_b[j]), 32'(acc_b[j]));
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
